aes128_iter_core: RTL and testbench

AES128_ITER_CORE -- requirements
Module: aes128_iter_core

---
 rtl/aes128_iter_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core with a compile-time unroll factor.
// Each RUN cycle applies ROUNDS_PER_CYCLE consecutive rounds. A block
// therefore takes 10/ROUNDS_PER_CYCLE cycles from accept to out_valid.
//
// Parameters
//   ROUNDS_PER_CYCLE : rounds evaluated per clock (1, 2, 5 or 10)
//   OUT_KEY_EN       : 1 = drive the round-10 key on key_out, 0 = tie it to zero
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : plaintext/key handshake (key, veri)
//   out_valid/out_ready : ciphertext handshake (cikis, key_out)
//   busy                : high while a block is being encrypted
module aes128_iter_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter bit          OUT_KEY_EN       = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] veri,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cikis,
    output logic [127:0] key_out,
    output logic         busy
);

    localparam int unsigned BLK_W   = 128;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAST_RD = 10;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the field inverse and maps 0 to 0
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] base;
        logic [7:0] inv;
        base = x;
        inv  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Round key r from round key r-1
    function automatic logic [BLK_W-1:0] next_key(input logic [BLK_W-1:0] k,
                                                  input logic [CNT_W-1:0] r);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^
             {rcon(r), 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One full round; byte i of the block is row i%4, column i/4
    function automatic logic [BLK_W-1:0] enc_round(input logic [BLK_W-1:0] s,
                                                   input logic [BLK_W-1:0] rk,
                                                   input logic             last);
        logic [7:0]       sb [16];
        logic [7:0]       sr [16];
        logic [7:0]       a0;
        logic [7:0]       a1;
        logic [7:0]       a2;
        logic [7:0]       a3;
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(s[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ gf_mul(a2, 8'h03) ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ gf_mul(a3, 8'h03),
                                     gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   st_q, st_d;
    logic [BLK_W-1:0]   rk_q, rk_d;
    logic [BLK_W-1:0]   ct_q, ct_d;
    logic [BLK_W-1:0]   ko_q, ko_d;
    logic [BLK_W-1:0]   chain_st;
    logic [BLK_W-1:0]   chain_rk;
    logic               last_step;
    logic               accept;

    // Unrolled round chain; stage g processes round cnt_q+g
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [BLK_W-1:0] st_in;
        logic [BLK_W-1:0] rk_in;
        logic [BLK_W-1:0] st_out;
        logic [BLK_W-1:0] rk_out;
        logic [CNT_W-1:0] ridx;

        if (g == 0) begin : g_first
            assign st_in = st_q;
            assign rk_in = rk_q;
        end else begin : g_next
            assign st_in = g_rnd[g-1].st_out;
            assign rk_in = g_rnd[g-1].rk_out;
        end

        assign ridx   = cnt_q + CNT_W'(g);
        assign rk_out = next_key(rk_in, ridx);
        // only the stage holding round 10 skips MixColumns
        assign st_out = enc_round(st_in, rk_out, ridx == CNT_W'(LAST_RD));
    end

    assign chain_st  = g_rnd[ROUNDS_PER_CYCLE-1].st_out;
    assign chain_rk  = g_rnd[ROUNDS_PER_CYCLE-1].rk_out;
    assign last_step = (cnt_q + CNT_W'(ROUNDS_PER_CYCLE - 1)) == CNT_W'(LAST_RD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            ko_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            ko_q    <= ko_d;
        end
    end

    // Next-state and handshake logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        st_d     = st_q;
        rk_d     = rk_q;
        ct_d     = ct_q;
        ko_d     = ko_q;
        in_ready = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                st_d  = chain_st;
                rk_d  = chain_rk;
                cnt_d = cnt_q + CNT_W'(ROUNDS_PER_CYCLE);
                if (last_step) begin
                    // saturate at 10 rather than step past it
                    cnt_d   = CNT_W'(LAST_RD);
                    ct_d    = chain_st;
                    ko_d    = chain_rk;
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // a new load overrides the DONE->IDLE handoff for zero-bubble streaming
        accept = in_valid && in_ready;
        if (accept) begin
            st_d    = veri ^ key;
            rk_d    = key;
            cnt_d   = CNT_W'(1);
            state_d = RUN;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign cikis     = ct_q;
    assign key_out   = OUT_KEY_EN ? ko_q : '0;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Testbench for aes128_iter_core: four unroll factors plus a key_out-disabled
// variant, driven from a table of known-answer vectors and a few sequences for
// backpressure, back-to-back streaming and reset during a block.
module tb_aes128_iter_core;

    localparam int NDUT = 5;
    localparam int NVEC = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] key_s     [NDUT];
    logic [127:0] veri_s    [NDUT];
    logic         in_ready  [NDUT];
    logic         out_valid [NDUT];
    logic         busy      [NDUT];
    logic [127:0] cikis     [NDUT];
    logic [127:0] key_out   [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned RPC = (g == 1) ? 2 : (g == 2) ? 5 : (g == 3) ? 10 : 1;
        localparam bit          KEN = (g == 4) ? 1'b0 : 1'b1;
        aes128_iter_core #(
            .ROUNDS_PER_CYCLE(RPC),
            .OUT_KEY_EN      (KEN)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .key      (key_s[g]),
            .veri     (veri_s[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .cikis    (cikis[g]),
            .key_out  (key_out[g]),
            .busy     (busy[g])
        );
    end

    typedef struct {
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] c;
        logic [127:0] ko;
        bit           kchk;
    } vec_t;

    vec_t tv [NVEC];

    function automatic int n_of(input int d);
        case (d)
            1:       return 5;
            2:       return 2;
            3:       return 1;
            default: return 10;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Present a pair; returns at the falling edge right after the accept edge
    task automatic start(input int d, input logic [127:0] k, input logic [127:0] p);
        int w;
        w = 0;
        while (!in_ready[d] && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("d%0d in_ready before load", d), 128'(in_ready[d]), 128'(1));
        in_valid[d] = 1'b1;
        key_s[d]    = k;
        veri_s[d]   = p;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    // Wait for out_valid while scrambling key/veri/in_valid; lat counts edges since accept
    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            in_valid[d] = 1'($urandom_range(0, 1));
            key_s[d]    = {$urandom, $urandom, $urandom, $urandom};
            veri_s[d]   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        in_valid[d] = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        vec_t v;

        tv[0] = '{k: 128'h2b7e151628aed2a6abf7158809cf4f3c, p: 128'h3243f6a8885a308d313198a2e0370734,
                  c: 128'h3925841d02dc09fbdc118597196a0b32, ko: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, kchk: 1'b1};
        tv[1] = '{k: 128'h000102030405060708090a0b0c0d0e0f, p: 128'h00112233445566778899aabbccddeeff,
                  c: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, ko: 128'h13111d7fe3944a17f307a78b4d2b30c5, kchk: 1'b1};
        tv[2] = '{k: 128'h0, p: 128'h0,
                  c: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, ko: 128'h0, kchk: 1'b0};

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            key_s[d]     = '0;
            veri_s[d]    = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("d%0d rst out_valid", d), 128'(out_valid[d]), 128'(0));
            chk($sformatf("d%0d rst busy", d), 128'(busy[d]), 128'(0));
            chk($sformatf("d%0d rst in_ready", d), 128'(in_ready[d]), 128'(1));
            chk($sformatf("d%0d rst cikis", d), cikis[d], 128'h0);
            chk($sformatf("d%0d rst key_out", d), key_out[d], 128'h0);
        end

        // known-answer vectors on every instance, with input churn during RUN
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < NVEC; i++) begin
                v = tv[i];
                out_ready[d] = 1'b0;
                start(d, v.k, v.p);
                chk($sformatf("d%0d v%0d busy", d, i), 128'(busy[d]), 128'(1));
                wait_done(d, lat);
                chk($sformatf("d%0d v%0d latency", d, i), 128'(lat), 128'(n_of(d)));
                chk($sformatf("d%0d v%0d cikis", d, i), cikis[d], v.c);
                if (d == 4)
                    chk($sformatf("d%0d v%0d key_out", d, i), key_out[d], 128'h0);
                else if (v.kchk)
                    chk($sformatf("d%0d v%0d key_out", d, i), key_out[d], v.ko);
                chk($sformatf("d%0d v%0d done in_ready", d, i), 128'(in_ready[d]), 128'(0));
                out_ready[d] = 1'b1;
                @(negedge clk);
                out_ready[d] = 1'b0;
                chk($sformatf("d%0d v%0d handoff out_valid", d, i), 128'(out_valid[d]), 128'(0));
                chk($sformatf("d%0d v%0d idle in_ready", d, i), 128'(in_ready[d]), 128'(1));
            end
        end

        // backpressure: 7 cycles of out_ready=0 with in_valid held high
        out_ready[0] = 1'b0;
        start(0, tv[0].k, tv[0].p);
        wait_done(0, lat);
        in_valid[0] = 1'b1;
        key_s[0]    = tv[1].k;
        veri_s[0]   = tv[1].p;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d cikis", c), cikis[0], tv[0].c);
            chk($sformatf("bp%0d out_valid", c), 128'(out_valid[0]), 128'(1));
            chk($sformatf("bp%0d in_ready", c), 128'(in_ready[0]), 128'(0));
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp release out_valid", 128'(out_valid[0]), 128'(0));
        chk("bp release busy", 128'(busy[0]), 128'(0));

        // back-to-back: second load on the handoff edge, no idle cycle
        for (int d = 0; d < 4; d++) begin
            out_ready[d] = 1'b1;
            start(d, tv[0].k, tv[0].p);
            wait_done(d, lat);
            chk($sformatf("b2b d%0d first latency", d), 128'(lat), 128'(n_of(d)));
            chk($sformatf("b2b d%0d first cikis", d), cikis[d], tv[0].c);
            chk($sformatf("b2b d%0d in_ready", d), 128'(in_ready[d]), 128'(1));
            in_valid[d] = 1'b1;
            key_s[d]    = tv[1].k;
            veri_s[d]   = tv[1].p;
            @(negedge clk);
            in_valid[d] = 1'b0;
            chk($sformatf("b2b d%0d handoff out_valid", d), 128'(out_valid[d]), 128'(0));
            chk($sformatf("b2b d%0d reload busy", d), 128'(busy[d]), 128'(1));
            wait_done(d, lat);
            chk($sformatf("b2b d%0d second latency", d), 128'(lat), 128'(n_of(d)));
            chk($sformatf("b2b d%0d second cikis", d), cikis[d], tv[1].c);
            @(negedge clk);
            out_ready[d] = 1'b0;
            chk($sformatf("b2b d%0d final out_valid", d), 128'(out_valid[d]), 128'(0));
        end

        // reset while the round counter is 4
        out_ready[0] = 1'b0;
        start(0, tv[0].k, tv[0].p);
        repeat (3) @(negedge clk);
        chk("mid-run busy", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-rst out_valid", 128'(out_valid[0]), 128'(0));
        chk("mid-rst busy", 128'(busy[0]), 128'(0));
        chk("mid-rst cikis", cikis[0], 128'h0);
        chk("mid-rst key_out", key_out[0], 128'h0);
        chk("mid-rst in_ready", 128'(in_ready[0]), 128'(1));
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        chk("aborted block never presented", 128'(seen), 128'(0));
        start(0, tv[1].k, tv[1].p);
        wait_done(0, lat);
        chk("post-rst latency", 128'(lat), 128'(10));
        chk("post-rst cikis", cikis[0], tv[1].c);
        chk("post-rst key_out", key_out[0], tv[1].ko);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
